// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file write port: two one-entry holding
// buffers (ALU, load), one write issued per cycle, $zero suppression, RAW hazard flags.
module regfile_wb_arbiter #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 5,
   parameter int PRIO_MODE = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_rd,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_rd,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   input  logic [ADDR_W-1:0] rs,
   input  logic [ADDR_W-1:0] rt,
   output logic [ADDR_W-1:0] rd,
   output logic [DATA_W-1:0] writedata,
   output logic              regwrite,
   output logic              grant,
   output logic              hazard_a,
   output logic              hazard_b
);

   logic              buf0_full, buf1_full;
   logic [ADDR_W-1:0] buf0_rd, buf1_rd;
   logic [DATA_W-1:0] buf0_data, buf1_data;
   logic              buf1_older;
   logic              ptr;
   logic              accept0, accept1;
   logic              issue, sel;
   logic [ADDR_W-1:0] sel_rd;
   logic [DATA_W-1:0] sel_data;

   assign req0_ready = rst_n & ~buf0_full;
   assign req1_ready = rst_n & ~buf1_full;
   assign accept0    = req0_valid & req0_ready;
   assign accept1    = req1_valid & req1_ready;
   assign issue      = buf0_full | buf1_full;

   always_comb begin
      sel = buf1_full;
      if (buf0_full && buf1_full) begin
         // Same destination: program order must be preserved, so age decides.
         if (buf0_rd == buf1_rd)  sel = buf1_older;
         else if (PRIO_MODE != 0) sel = 1'b0;
         else                     sel = ptr;
      end
   end

   assign sel_rd   = sel ? buf1_rd   : buf0_rd;
   assign sel_data = sel ? buf1_data : buf0_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf0_full <= 1'b0;
         buf0_rd   <= '0;
         buf0_data <= '0;
      end else if (accept0) begin
         buf0_full <= 1'b1;
         buf0_rd   <= req0_rd;
         buf0_data <= req0_data;
      end else if (issue && !sel) begin
         buf0_full <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf1_full <= 1'b0;
         buf1_rd   <= '0;
         buf1_data <= '0;
      end else if (accept1) begin
         buf1_full <= 1'b1;
         buf1_rd   <= req1_rd;
         buf1_data <= req1_data;
      end else if (issue && sel) begin
         buf1_full <= 1'b0;
      end
   end

   // Relative age stamp: set when buf0 is refilled after buf1; a same-edge pair leaves req0 older.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  buf1_older <= 1'b0;
      else if (accept0 || accept1) buf1_older <= accept0 & ~accept1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr       <= 1'b0;
         rd        <= '0;
         writedata <= '0;
         grant     <= 1'b0;
         regwrite  <= 1'b0;
      end else if (issue) begin
         ptr       <= ~sel;
         rd        <= sel_rd;
         writedata <= sel_data;
         grant     <= sel;
         regwrite  <= |sel_rd;
      end else begin
         regwrite  <= 1'b0;
      end
   end

   assign hazard_a = (|rs) & ((buf0_full & (buf0_rd == rs)) | (buf1_full & (buf1_rd == rs)) |
                              (regwrite & (rd == rs)));
   assign hazard_b = (|rt) & ((buf0_full & (buf0_rd == rt)) | (buf1_full & (buf1_rd == rt)) |
                              (regwrite & (rd == rt)));

endmodule
